// File: rtl/ahb_drain_pkg.sv
// Shared types and constants for the FIFO-to-AHB-Lite drain stage.
package ahb_drain_pkg;

   // AHB-Lite transfer types.
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   // Drain controller states: one pop, one single write, strictly sequential.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_POP   = 3'd1,
      ST_FETCH = 3'd2,
      ST_ADDR  = 3'd3,
      ST_DATA  = 3'd4,
      ST_ERR   = 3'd5
   } drain_state_t;

   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

endpackage

// File: rtl/ahb_drain_addr_gen.sv
// Write-address generator for the drain stage.
// Holds the next write address; steps by one word on each advance strobe.
// Build option AHB_DRAIN_WRAP_EN: wrap back to the base after WORDS words
// (circular window); otherwise the address runs linearly modulo 2^ADDR_W.
module ahb_drain_addr_gen #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       WORDS     = 10
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr
);

   // Base is forced word aligned so the low address bits are always zero.
   localparam logic [ADDR_W-1:0] BASE_ALIGNED = {BASE_ADDR[ADDR_W-1:2], 2'b00};
   localparam logic [ADDR_W-1:0] WORD_STEP    = ADDR_W'(4);

   // A zero-sized window is meaningless in either build.
   if (WORDS == 0) begin : g_words_check
      $error("ahb_drain_addr_gen: WORDS must be nonzero");
   end

`ifdef AHB_DRAIN_WRAP_EN
   localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ALIGNED + ADDR_W'(4 * (WORDS - 1));
`endif

   logic [ADDR_W-1:0] addr_q;

   // Address register: base on reset, one word forward per completed write.
   always_ff @(posedge clk) begin
      if (srst) begin
         addr_q <= BASE_ALIGNED;
      end else if (advance) begin
`ifdef AHB_DRAIN_WRAP_EN
         if (addr_q == LAST_ADDR) begin
            addr_q <= BASE_ALIGNED;
         end else begin
            addr_q <= addr_q + WORD_STEP;
         end
`else
         addr_q <= addr_q + WORD_STEP;
`endif
      end
   end

   assign addr = addr_q;

endmodule

// File: rtl/ahb_fifo_drain.sv
// FIFO drain stage: pops one FIFO entry at a time and writes it to memory
// as an AHB-Lite single word WRITE, with one transfer in flight.
// Build option AHB_DRAIN_WRAP_EN (see ahb_drain_addr_gen) selects a
// circular address window of WORDS words instead of a linear address.
module ahb_fifo_drain
   import ahb_drain_pkg::*;
#(
   parameter int unsigned       DATA_W    = 4,
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       WORDS     = 10,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              enable,
   input  logic              err_clr,
   output logic              fifo_req,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic              fifo_valid,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [31:0]       HWDATA,
   input  logic              HREADY,
   input  logic              HRESP,
   output logic [CNT_W-1:0]  done_count,
   output logic              err
);

   if (DATA_W > 32) begin : g_width_check
      $error("ahb_fifo_drain: DATA_W must fit in HWDATA");
   end

   drain_state_t      state_reg, state_next;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  done_count_reg;
   logic              err_reg;
   logic              write_okay;
   logic              write_error;

   // A write finishes OKAY on the ready cycle of its data phase; an error
   // is taken on the first ERROR cycle, whatever HREADY says.
   assign write_okay  = (state_reg == ST_DATA) && HREADY && (HRESP == HRESP_OKAY);
   assign write_error = (state_reg == ST_DATA) && (HRESP == HRESP_ERROR);

   ahb_drain_addr_gen #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR),
      .WORDS     (WORDS)
   ) u_addr_gen (
      .clk     (HCLK),
      .srst    (HRESET),
      .advance (write_okay),
      .addr    (HADDR)
   );

   // State register.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and bus/FIFO strobes decoded from the current state.
   always_comb begin
      state_next = state_reg;
      fifo_req   = 1'b0;
      HTRANS     = HTRANS_IDLE;
      HWRITE     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (enable && !err_reg) begin
               state_next = ST_POP;
            end
         end
         ST_POP: begin
            fifo_req   = 1'b1;
            state_next = ST_FETCH;
         end
         ST_FETCH: begin
            // An empty FIFO returns valid=0: give up quietly and retry later.
            state_next = fifo_valid ? ST_ADDR : ST_IDLE;
         end
         ST_ADDR: begin
            HTRANS = HTRANS_NONSEQ;
            HWRITE = 1'b1;
            if (HREADY) begin
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (write_error) begin
               state_next = ST_ERR;
            end else if (write_okay) begin
               state_next = enable ? ST_POP : ST_IDLE;
            end
         end
         ST_ERR: begin
            if (err_clr) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Capture the popped entry; it stays put through the whole data phase.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wdata_q <= '0;
      end else if ((state_reg == ST_FETCH) && fifo_valid) begin
         wdata_q <= fifo_data;
      end
   end

   // Count OKAY-completed writes; the counter wraps naturally.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         done_count_reg <= '0;
      end else if (write_okay) begin
         done_count_reg <= done_count_reg + CNT_W'(1);
      end
   end

   // Sticky error: set by an ERROR response, released only by err_clr in ERR.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         err_reg <= 1'b0;
      end else if (write_error) begin
         err_reg <= 1'b1;
      end else if ((state_reg == ST_ERR) && err_clr) begin
         err_reg <= 1'b0;
      end
   end

   assign HSIZE      = HSIZE_WORD;
   assign HBURST     = HBURST_SINGLE;
   assign HWDATA     = 32'(wdata_q);
   assign done_count = done_count_reg;
   assign err        = err_reg;

endmodule

// File: tb/tb_ahb_fifo_drain.sv
// Bench for ahb_fifo_drain: FIFO model + AHB slave model + scoreboard.
// Honours AHB_DRAIN_WRAP_EN the same way as the design build.
`timescale 1ns/1ps
module tb_ahb_fifo_drain;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        enable = 1'b0;
   logic        err_clr = 1'b0;
   logic        fifo_req;
   logic [3:0]  fifo_data = 4'h0;
   logic        fifo_valid = 1'b0;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic        HREADY = 1'b1;
   logic        HRESP = 1'b0;
   logic [15:0] done_count;
   logic        err;

   int checks = 0;
   int errors = 0;

   // FIFO contents waiting to be popped, and expected {addr, data} per write
   logic [3:0]  fq[$];
   logic [35:0] sb[$];
   logic [31:0] exp_addr = 32'h0;
   logic [31:0] cap_addr = 32'h0;
   logic [31:0] last_addr = 32'h0;
   logic        in_data = 1'b0;
   logic        hold = 1'b0;
   logic        err2 = 1'b0;
   int          dcnt = 0;
   int          ws_cfg = 0;
   logic        err_cfg = 1'b0;
   int          req_total = 0;
   int          n_hold = 0;
   int          n_err = 0;

   ahb_fifo_drain dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .enable     (enable),
      .err_clr    (err_clr),
      .fifo_req   (fifo_req),
      .fifo_data  (fifo_data),
      .fifo_valid (fifo_valid),
      .HADDR      (HADDR),
      .HTRANS     (HTRANS),
      .HWRITE     (HWRITE),
      .HSIZE      (HSIZE),
      .HBURST     (HBURST),
      .HWDATA     (HWDATA),
      .HREADY     (HREADY),
      .HRESP      (HRESP),
      .done_count (done_count),
      .err        (err)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] next_addr(input logic [31:0] a);
`ifdef AHB_DRAIN_WRAP_EN
      return (a == 32'h24) ? 32'h0 : a + 32'd4;
`else
      return a + 32'd4;
`endif
   endfunction

   // Slave responses, bus monitor and FIFO model, all evaluated mid-cycle.
   always @(negedge HCLK) begin
      if (HRESET) begin
         in_data = 1'b0; hold = 1'b0; err2 = 1'b0; dcnt = 0;
         fifo_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
      end else begin
         if (err2) begin
            HREADY = 1'b1; HRESP = 1'b1; err2 = 1'b0;
         end else if (in_data && err_cfg) begin
            HREADY = 1'b0; HRESP = 1'b1;
         end else if (in_data) begin
            HREADY = (dcnt >= ws_cfg); HRESP = 1'b0;
         end else begin
            HREADY = 1'b1; HRESP = 1'b0;
         end
         if (in_data) begin
            if (HRESP || HREADY) begin
               chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  logic [35:0] e;
                  e = sb.pop_front();
                  chk(HRESP ? "err_addr" : "wr_addr", cap_addr, e[35:4]);
                  if (HRESP) begin
                     err_cfg = 1'b0; err2 = 1'b1; n_err++;
                  end else begin
                     chk("wr_data", HWDATA, 32'(e[3:0]));
                     exp_addr = next_addr(exp_addr);
                     last_addr = cap_addr;
                     $display("write addr=%08h data=%08h done=%0d", cap_addr, HWDATA, done_count + 16'd1);
                  end
               end
               in_data = 1'b0;
            end else begin
               if (sb.size() != 0) chk("hold_data", HWDATA, 32'(sb[0][3:0]));
               n_hold++; dcnt++;
            end
         end
         if (HTRANS == 2'b10 && HREADY) begin
            chk("hwrite", 32'(HWRITE), 32'd1);
            chk("hsize_hburst", 32'({HSIZE, HBURST}), 32'({3'b010, 3'b000}));
            chk("haddr_align", 32'(HADDR[1:0]), 32'd0);
            cap_addr = HADDR; in_data = 1'b1; dcnt = 0;
         end
         if (fifo_req) begin
            req_total++;
            hold = 1'b1;
            if (fq.size() != 0) begin
               fifo_data = fq.pop_front();
               fifo_valid = 1'b1;
               sb.push_back({exp_addr, fifo_data});
            end else begin
               fifo_valid = 1'b0;
            end
         end else if (hold) begin
            hold = 1'b0;
         end else begin
            fifo_valid = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic do_reset();
      HRESET = 1'b1; enable = 1'b0; err_clr = 1'b0;
      ws_cfg = 0; err_cfg = 1'b0;
      fq.delete(); sb.delete(); exp_addr = 32'h0;
      tick(); tick();
      HRESET = 1'b0;
   endtask

   task automatic wait_done(input int target, input string tag);
      for (int i = 0; i < 400 && done_count != 16'(target); i++) tick();
      chk(tag, 32'(done_count), 32'(target));
   endtask

   initial begin
      logic [8:0] reqs;
      logic       busy;
      int         r0;

      // Reset state
      do_reset();
      chk("rst_fifo_req", 32'(fifo_req), 32'd0);
      chk("rst_htrans", 32'(HTRANS), 32'd0);
      chk("rst_hwrite", 32'(HWRITE), 32'd0);
      chk("rst_hwdata", HWDATA, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_done", 32'(done_count), 32'd0);
      chk("rst_haddr", HADDR, 32'h0);

      // 1: three back-to-back zero-wait writes
      fq.push_back(4'h3); fq.push_back(4'h7); fq.push_back(4'hA);
      enable = 1'b1;
      wait_done(3, "t1_done");
      chk("t1_last_addr", last_addr, 32'h8);

      // 2: empty FIFO polling, one request every 3 cycles, no bus traffic
      enable = 1'b0;
      repeat (6) tick();
      enable = 1'b1;
      reqs = '0; busy = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         reqs[i] = fifo_req;
         if (HTRANS != 2'b00) busy = 1'b1;
      end
      chk("t2_req_pattern", 32'(reqs), 32'h049);
      chk("t2_htrans_idle", 32'(busy), 32'd0);
      chk("t2_done", 32'(done_count), 32'd3);

      // 3: two wait states in the data phase
      do_reset();
      ws_cfg = 2; n_hold = 0;
      fq.push_back(4'h5);
      enable = 1'b1;
      wait_done(1, "t3_done");
      chk("t3_hold_cycles", 32'(n_hold), 32'd2);
      chk("t3_next_haddr", HADDR, 32'h4);
      ws_cfg = 0;

      // 4: ERROR response, sticky err, retry at the same address
      err_cfg = 1'b1;
      fq.push_back(4'h6);
      for (int i = 0; i < 50 && !err; i++) tick();
      chk("t4_err_set", 32'(err), 32'd1);
      chk("t4_htrans_idle", 32'(HTRANS), 32'd0);
      r0 = req_total;
      fq.push_back(4'h9);
      repeat (6) tick();
      chk("t4_no_pop", 32'(req_total - r0), 32'd0);
      chk("t4_err_sticky", 32'(err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t4_err_clr", 32'(err), 32'd0);
      wait_done(2, "t4_done");
      chk("t4_retry_addr", last_addr, 32'h4);
      chk("t4_err_count", 32'(n_err), 32'd1);

      // 5: 11 writes, window wrap or linear address
      do_reset();
      for (int i = 0; i < 11; i++) fq.push_back(4'(i + 1));
      enable = 1'b1;
      wait_done(11, "t5_done");
`ifdef AHB_DRAIN_WRAP_EN
      chk("t5_last_addr", last_addr, 32'h0);
`else
      chk("t5_last_addr", last_addr, 32'h28);
`endif

      // 6: reset while the address phase is on the bus
      fq.push_back(4'hC);
      for (int i = 0; i < 40 && HTRANS != 2'b10; i++) tick();
      chk("t6_in_addr", 32'(HTRANS), 32'h2);
      HRESET = 1'b1;
      fq.delete(); sb.delete(); exp_addr = 32'h0;
      tick();
      chk("t6_htrans", 32'(HTRANS), 32'd0);
      chk("t6_haddr", HADDR, 32'h0);
      chk("t6_done", 32'(done_count), 32'd0);
      chk("t6_err", 32'(err), 32'd0);
      tick();
      HRESET = 1'b0;
      enable = 1'b0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
